// File: rtl/bias_stream_ctrl.sv
// rtl/bias_stream_ctrl.sv - bias ROM sweep sequencer feeding an ap_fifo through a 2-entry skid buffer
// Optional feature macro: BIAS_STREAM_CTRL_STALL_CNT_EN (adds stall_cycles output)
module bias_stream_ctrl #(
  parameter int MEM_SIZE   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PASSES = 1
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_idle,
  output logic                        ap_done,
  output logic [$clog2(MEM_SIZE)-1:0] bias_address,
  output logic                        bias_ce,
  input  logic [DATA_WIDTH-1:0]       bias_q,
  output logic [DATA_WIDTH-1:0]       output_V_din,
  input  logic                        output_V_full_n,
  output logic                        output_V_write
`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [AW-1:0]         r_rd_addr;
  logic [PW-1:0]         r_pass_cnt;
  logic                  r_inflight;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;

  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_load;
  logic                  w_issue;
  logic [1:0]            w_occ_next;
  logic                  w_last_addr;
  logic                  w_last_pass;

  // A word leaves whenever the head is valid and the FIFO has room; the
  // ROM word read last cycle always lands in the buffer this cycle.
  assign w_pop       = (r_occ != 2'd0) && output_V_full_n;
  assign w_push      = r_inflight;
  // Slots committed after this cycle's pop; issuing only below 2 means a
  // returning ROM word always finds a free entry, whatever full_n does.
  assign w_load      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == S_RUN) && (w_load < 3'd2);
  assign w_occ_next  = r_occ + {1'b0, w_push} - {1'b0, w_pop};
  assign w_last_addr = (r_rd_addr == AW'(MEM_SIZE - 1));
  assign w_last_pass = (r_pass_cnt == PW'(NUM_PASSES - 1));

  assign ap_idle        = (r_state == S_IDLE);
  assign ap_done        = (r_state == S_DONE);
  assign bias_ce        = w_issue;
  assign bias_address   = r_rd_addr;
  assign output_V_write = w_pop;
  assign output_V_din   = r_buf0;

  // Control FSM: address/pass sequencing and drain-to-done detection
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= S_IDLE;
      r_rd_addr  <= '0;
      r_pass_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_state    <= S_RUN;
            r_rd_addr  <= '0;
            r_pass_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (w_last_addr) begin
              r_rd_addr <= '0;
              if (w_last_pass) r_state <= S_DRAIN;
              else             r_pass_cnt <= r_pass_cnt + PW'(1);
            end else begin
              r_rd_addr <= r_rd_addr + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!r_inflight && (w_occ_next == 2'd0)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tracks the read issued last cycle, whose data arrives this cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_inflight <= 1'b0;
    else           r_inflight <= w_issue;
  end

  // Two-entry skid buffer; buf0 is the head and keeps the last popped word when empty
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_occ  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      r_occ <= w_occ_next;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= bias_q;
          else               r_buf1 <= bias_q;
        end
        2'b01: begin
          if (r_occ == 2'd2) r_buf0 <= r_buf1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= bias_q;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= bias_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  assign stall_cycles = r_stall_cnt;

  // Saturating count of cycles where a ready word is blocked by a full FIFO
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && ap_start) begin
      r_stall_cnt <= '0;
    end else if (((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                 (r_occ != 2'd0) && !output_V_full_n &&
                 (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bias_stream_ctrl.sv
// tb/tb_bias_stream_ctrl.sv - scoreboard bench for bias_stream_ctrl
module tb_bias_stream_ctrl;

  localparam int MEM_SIZE = 4;
  localparam int DW       = 16;
  localparam int NP       = 3;
  localparam int TOTAL    = MEM_SIZE * NP;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_idle;
  logic          ap_done;
  logic [1:0]    bias_address;
  logic          bias_ce;
  logic [DW-1:0] bias_q = '0;
  logic [DW-1:0] output_V_din;
  logic          output_V_full_n = 1'b1;
  logic          output_V_write;
`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  bias_stream_ctrl #(.MEM_SIZE(MEM_SIZE), .DATA_WIDTH(DW), .NUM_PASSES(NP)) u_dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .ap_start        (ap_start),
    .ap_idle         (ap_idle),
    .ap_done         (ap_done),
    .bias_address    (bias_address),
    .bias_ce         (bias_ce),
    .bias_q          (bias_q),
    .output_V_din    (output_V_din),
    .output_V_full_n (output_V_full_n),
    .output_V_write  (output_V_write)
`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  logic [DW-1:0] rom [0:MEM_SIZE-1];
  initial begin
    rom[0] = 16'h0011;
    rom[1] = 16'h0022;
    rom[2] = 16'h0033;
    rom[3] = 16'h0044;
  end

  // ROM model with one cycle read latency
  always @(posedge ap_clk) if (bias_ce) bias_q <= rom[bias_address];

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  int start_cyc = 0;
  int first_wr_cyc = -1;
  int last_wr_cyc = -1;
  int exp_done_cyc = -1;
  int done_cnt = 0;
  int wr_cnt = 0;
  int issue_cnt = 0;
  int wrap_cnt = 0;
  logic [1:0] first_addr = 2'd3;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_din = '0;
  logic [DW-1:0] exp_word;

  // Output monitor: scoreboard pops, handshake rules, done timing
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (bias_ce) begin
        if (issue_cnt == 0) first_addr = bias_address;
        issue_cnt++;
        if (bias_address == 2'd3) wrap_cnt++;
      end
      if (!output_V_full_n) begin
        checks++;
        if (output_V_write !== 1'b0) begin
          errors++;
          $display("FAIL write_while_full: write=%b required 0", output_V_write);
        end
      end
      if (prev_stall) begin
        checks++;
        if (output_V_din !== prev_din) begin
          errors++;
          $display("FAIL din_stable: din=%h required %h", output_V_din, prev_din);
        end
      end
      prev_stall = !output_V_full_n && (exp_q.size() > 0) && (output_V_din === exp_q[0]);
      prev_din = output_V_din;
      if (output_V_write) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: din=%h required no write", output_V_din);
        end else begin
          exp_word = exp_q.pop_front();
          if (output_V_din !== exp_word) begin
            errors++;
            $display("FAIL write_data: din=%h required %h", output_V_din, exp_word);
          end
          if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
        end
        wr_cnt++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (bias_ce) begin
        checks++;
        if (issue_cnt - wr_cnt > 2) begin
          errors++;
          $display("FAIL outstanding: %0d words outstanding required <=2", issue_cnt - wr_cnt);
        end
      end
      if (ap_done) begin
        done_cnt++;
        checks++;
        if (cyc != exp_done_cyc) begin
          errors++;
          $display("FAIL done_timing: done at cycle %0d required %0d", cyc, exp_done_cyc);
        end
      end
    end
  end

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_start;
    first_wr_cyc = -1;
    last_wr_cyc = -1;
    exp_done_cyc = -1;
    done_cnt = 0;
    wr_cnt = 0;
    issue_cnt = 0;
    wrap_cnt = 0;
    first_addr = 2'd3;
    for (int p = 0; p < NP; p++)
      for (int a = 0; a < MEM_SIZE; a++) exp_q.push_back(rom[a]);
    ap_start = 1'b1;
    start_cyc = cyc;
    tick();
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: no ap_done within %0d cycles", budget);
    end
  endtask

  task automatic check_run_end(input string name);
    checks++;
    if (wr_cnt != TOTAL) begin
      errors++;
      $display("FAIL %s_count: writes=%0d required %0d", name, wr_cnt, TOTAL);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d words left required 0", name, exp_q.size());
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_count: dones=%0d required 1", name, done_cnt);
    end
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || bias_ce !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: idle=%b done=%b ce=%b required 1 0 0", ap_idle, ap_done, bias_ce);
    end
    checks++;
    if (bias_address !== 2'd0 || output_V_write !== 1'b0 || output_V_din !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%0d write=%b din=%h required 0 0 0000",
               bias_address, output_V_write, output_V_din);
    end
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_rate;
    output_V_full_n = 1'b1;
    do_start();
    wait_done(100);
    check_run_end("full_rate");
    checks++;
    if (first_wr_cyc - start_cyc != 3) begin
      errors++;
      $display("FAIL first_latency: %0d cycles required 3", first_wr_cyc - start_cyc);
    end
    checks++;
    if (last_wr_cyc - first_wr_cyc != TOTAL - 1) begin
      errors++;
      $display("FAIL throughput: span=%0d required %0d", last_wr_cyc - first_wr_cyc, TOTAL - 1);
    end
    checks++;
    if (wrap_cnt != NP) begin
      errors++;
      $display("FAIL addr_wrap: last-address reads=%0d required %0d", wrap_cnt, NP);
    end
    tick();
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_done: idle=%b required 1", ap_idle);
    end
  endtask

  task automatic test_backpressure;
    int k;
    do_start();
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      tick();
      if (first_wr_cyc >= 0) begin
        k = cyc - first_wr_cyc;
        if (k >= 2 && k <= 6) output_V_full_n = 1'b0;
        else if (k > 6)       output_V_full_n = ((k % 2) == 1);
        else                  output_V_full_n = 1'b1;
      end
    end
    output_V_full_n = 1'b1;
    wait_done(50);
    check_run_end("backpressure");
    tick();
  endtask

  task automatic test_start_ignored;
    output_V_full_n = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) tick();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    wait_done(100);
    for (int i = 0; i < 6; i++) tick();
    check_run_end("start_ignored");
  endtask

  task automatic test_abort;
    output_V_full_n = 1'b1;
    do_start();
    for (int i = 0; i < 100 && wr_cnt < 2; i++) tick();
    checks++;
    if (wr_cnt < 2) begin
      errors++;
      $display("FAIL abort_wait: writes=%0d required 2", wr_cnt);
    end
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || bias_ce !== 1'b0 || bias_address !== 2'd0 ||
        output_V_write !== 1'b0 || output_V_din !== 16'h0) begin
      errors++;
      $display("FAIL abort_async: idle=%b done=%b ce=%b addr=%0d write=%b din=%h required 1 0 0 0 0 0000",
               ap_idle, ap_done, bias_ce, bias_address, output_V_write, output_V_din);
    end
    exp_q.delete();
    exp_done_cyc = -1;
    prev_stall = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d required 0", done_cnt);
    end
    do_start();
    wait_done(100);
    check_run_end("restart");
    checks++;
    if (first_addr !== 2'd0) begin
      errors++;
      $display("FAIL restart_addr: first address=%0d required 0", first_addr);
    end
    tick();
  endtask

`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
  task automatic test_stall_cnt;
    output_V_full_n = 1'b1;
    do_start();
    for (int i = 0; i < 50 && first_wr_cyc < 0; i++) tick();
    output_V_full_n = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    output_V_full_n = 1'b1;
    wait_done(100);
    tick();
    checks++;
    if (stall_cycles !== 32'd7) begin
      errors++;
      $display("FAIL stall_count: stall_cycles=%0d required 7", stall_cycles);
    end
    do_start();
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL stall_clear: stall_cycles=%0d required 0", stall_cycles);
    end
    wait_done(100);
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_start_ignored();
    test_abort();
`ifdef BIAS_STREAM_CTRL_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bias_stream_ctrl.md
Name: bias_stream_ctrl

Overview:
Sequencer for one single-port bias ROM with 1-cycle read latency.
- On a start pulse it reads every bias word in address order and pushes it into a downstream FIFO through the ap_fifo full_n/write handshake.
- It repeats the full sweep NUM_PASSES times, one pass per output tile of the conv layer.
- It sits between the rom instance of a conv layer and the layer's bias output FIFO, and replaces the free-running HLS bias streamer so the layer controller can schedule bias delivery.

Parameters:
- MEM_SIZE, 16, number of bias words in the ROM (≥2).
- DATA_WIDTH, 16, bias word width; matches coeff_width.
- NUM_PASSES, 1, number of full ROM sweeps per start (≥1).

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  single-cycle start request.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse after the final word transfers.
- bias_address  out  $clog2(MEM_SIZE)  ROM read address.
- bias_ce  out  1  ROM read enable.
- bias_q  in  DATA_WIDTH  ROM data, valid the cycle after bias_ce.
- output_V_din  out  DATA_WIDTH  bias word to the FIFO.
- output_V_full_n  in  1  FIFO not full.
- output_V_write  out  1  FIFO write strobe.

Behaviour:
Reset (asynchronous, active-low):
- State = IDLE, ap_idle=1, ap_done=0, bias_ce=0, bias_address=0, output_V_write=0, output_V_din=0.
- Skid buffer empty; all counters 0.
- Assertion mid-operation aborts immediately. No ap_done; partial stream is discarded by the system.

States:
- IDLE: ap_idle=1.
  - ap_start=1 → RUN; rd_addr=0, pass_cnt=0, issued=0.
- RUN: issues ROM reads and drains the skid buffer.
  - When the last read of the last pass has been issued → DRAIN.
- DRAIN: no new reads; drains in-flight and buffered words.
  - When the buffer is empty and nothing is in flight → DONE.
- DONE: ap_done=1 for exactly one cycle → IDLE.
- ap_start outside IDLE is ignored (not queued).

Skid buffer:
- 2-entry FIFO capturing bias_q, written the cycle after bias_ce.
- Read issue rule: bias_ce=1 in RUN only when (occupancy + inflight) < 2, evaluated with this cycle's pop. This guarantees no overflow under any backpressure pattern.
- On issue: rd_addr increments. At MEM_SIZE-1 it wraps to 0 and pass_cnt increments.
- Last issue occurs at rd_addr=MEM_SIZE-1 with pass_cnt=NUM_PASSES-1.

Output handshake:
- output_V_write = buffer_nonempty & output_V_full_n.
- output_V_din = buffer head, combinational from the registered head.
- A transfer occurs when output_V_write=1; head pops the same cycle.
- output_V_write is never asserted while full_n=0; din holds until transferred.
- Simultaneous push and pop in one cycle is allowed; occupancy is unchanged.

Latency and throughput:
- ap_start → first bias_ce: 1 cycle.
- First bias_ce → first output_V_write: 2 cycles (ROM latency + buffer register), given full_n=1.
- Steady state: 1 word/cycle.
- Total words = MEM_SIZE × NUM_PASSES, emitted in order 0..MEM_SIZE-1 repeated.
- ap_done asserts the cycle after the final transfer.

Optional Feature:
Macro BIAS_STREAM_CTRL_STALL_CNT_EN.
- Defined: adds output stall_cycles (32-bit). It counts cycles with buffer_nonempty & !output_V_full_n. It clears on ap_start accepted in IDLE and saturates at 0xFFFFFFFF. It holds its value in IDLE/DONE; reset value is 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- MEM_SIZE=4, NUM_PASSES=1, ROM={0x0011,0x0022,0x0033,0x0044}, full_n=1, start → writes 0x0011..0x0044 on 4 consecutive cycles; first write 3 cycles after start; ap_done one cycle after 4th write.
- NUM_PASSES=3, same ROM → 12 writes in sequence 11,22,33,44 repeated; bias_address wraps 3→0 twice; single ap_done.
- full_n low for cycles 2-6 after first write, then toggled every cycle → no lost or duplicated words; din stable while full_n=0; bias_ce never leaves >2 words outstanding.
- ap_start pulsed again mid-RUN → ignored; exactly MEM_SIZE×NUM_PASSES writes, one ap_done.
- ap_rst_n low for 1 cycle mid-stream after word 2 → outputs return to reset values asynchronously; no ap_done; a subsequent start restarts at address 0.
- With BIAS_STREAM_CTRL_STALL_CNT_EN, full_n held low 7 cycles during a non-empty buffer → stall_cycles=7 at ap_done; a new start clears it to 0.
